// File: rtl/multiword_adder_ctrl.sv
// Multi-word add/subtract sequencer: one B-bit adder slice is reused once per word,
// least-significant word first, with the carry held in a register between words.
module multiword_adder_ctrl #(
    parameter int B     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [B*WORDS-1:0]   a,
    input  logic [B*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [B*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg;
    logic                 carry_reg;
    logic                 sub_reg;
    logic [B*WORDS-1:0]   a_reg, b_reg, sum_reg;
    logic                 cout_reg, ovf_reg;

    logic [B-1:0]         a_words [WORDS];
    logic [B-1:0]         b_words [WORDS];
    logic [B-1:0]         a_w, b_w;
    logic [B:0]           slice;
    logic                 slice_ovf;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign a_words[gi] = a_reg[gi*B +: B];
            assign b_words[gi] = b_reg[gi*B +: B];
        end
    endgenerate

    // Subtraction is a + ~b + 1; the +1 enters as the initial carry loaded at start.
    assign a_w       = a_words[idx_reg];
    assign b_w       = b_words[idx_reg] ^ {B{sub_reg}};
    assign slice     = {1'b0, a_w} + {1'b0, b_w} + {{B{1'b0}}, carry_reg};
    assign slice_ovf = (a_w[B-1] == b_w[B-1]) && (slice[B-1] != a_w[B-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sub_reg   <= sub;
                        carry_reg <= sub;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx_reg == IDX_W'(i)) sum_reg[i*B +: B] <= slice[B-1:0];
                    end
                    carry_reg <= slice[B];
                    if (idx_reg == LAST_IDX) begin
                        cout_reg <= slice[B];
                        ovf_reg  <= slice_ovf;
                        idx_reg  <= '0;
                    end else begin
                        idx_reg  <= idx_reg + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
